arquitetura_onchip_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 8192×32 on-chip RAM between two requesters, e.g. the scheduler core and a DMA/loader. It gives each master a pipelined Avalon-MM-style port with `waitrequest` and `readdatavalid`. It drives the RAM's `address`/`byteenable`/`chipselect`/`write`/`writedata`/`clken`/`reset_req` pins. Arbitration is round-robin, one access per cycle. Read data is returned exactly one cycle after acceptance.

---
 rtl/arquitetura_onchip_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_arquitetura_onchip_mem_arbiter.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arquitetura_onchip_mem_arbiter.sv
// Round-robin arbiter that lets two pipelined masters share one
// single-port RAM.
// Ports: clk/reset; per master m0_*/m1_* (address, byteenable,
// read, write, writedata in; waitrequest, readdata,
// readdatavalid out); RAM side mem_* (address, byteenable,
// chipselect, write, writedata, clken, reset_req out;
// readdata in).
module arquitetura_onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  output logic                mem_reset_req,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rd_acc;

  // r_last: 1 means m1 was granted last, so m0 wins a conflict
  logic r_last;
  logic r_rd_pend;
  logic r_rd_id;
  logic w_last_nxt;
  logic w_rd_pend_nxt;
  logic w_rd_id_nxt;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        w_req0 & w_req1: begin
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end
        w_req0 & ~w_req1: w_gnt0 = 1'b1;
        ~w_req0 & w_req1: w_gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  // a simultaneous read+write is treated as a write only
  assign w_rd_acc = (w_gnt0 & m0_read & ~m0_write)
                  | (w_gnt1 & m1_read & ~m1_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
    end else begin
      r_last    <= w_last_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_rd_id   <= w_rd_id_nxt;
    end
  end

  always_comb begin
    w_last_nxt    = r_last;
    w_rd_pend_nxt = w_rd_acc;
    w_rd_id_nxt   = r_rd_id;
    if (w_gnt0 | w_gnt1) begin
      w_last_nxt = w_gnt1;
    end
    if (w_rd_acc) begin
      w_rd_id_nxt = w_gnt1;
    end
  end

  always_comb begin
    mem_chipselect = w_gnt0 | w_gnt1;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    unique case (1'b1)
      w_gnt0: begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = m0_write;
      end
      w_gnt1: begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        mem_write      = m1_write;
      end
      default: ;
    endcase
    m0_waitrequest   = reset | (w_req0 & ~w_gnt0);
    m1_waitrequest   = reset | (w_req1 & ~w_gnt1);
    // reset in the response cycle drops the pending strobe
    m0_readdatavalid = r_rd_pend & ~r_rd_id & ~reset;
    m1_readdatavalid = r_rd_pend & r_rd_id & ~reset;
  end

  assign m0_readdata   = mem_readdata;
  assign m1_readdata   = mem_readdata;
  assign mem_clken     = 1'b1;
  assign mem_reset_req = reset;

endmodule

// File: tb/tb_arquitetura_onchip_mem_arbiter.sv
// Testbench for arquitetura_onchip_mem_arbiter: RAM model plus
// a transaction-level reference of grants, memory and responses.
module tb_arquitetura_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken, mem_reset_req;
  logic [31:0] mem_readdata;

  always #5 clk = ~clk;

  arquitetura_onchip_mem_arbiter #(
    .ADDR_W(13),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m0_address(m0_address),
    .m0_byteenable(m0_byteenable),
    .m0_read(m0_read),
    .m0_write(m0_write),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address),
    .m1_byteenable(m1_byteenable),
    .m1_read(m1_read),
    .m1_write(m1_write),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req),
    .mem_readdata(mem_readdata)
  );

  // RAM model: synchronous, 1-cycle read latency
  logic [31:0] ram [8192];
  logic [31:0] ram_q;
  assign mem_readdata = ram_q;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  // reference model state
  logic [31:0] ref_mem [8192];
  bit          ref_last;
  bit          p_valid;
  bit          p_id;
  logic [31:0] p_data;
  bit          g0, g1;
  bit          e_wr0, e_wr1, e_cs, e_we, e_rdv0, e_rdv1;
  logic [12:0] e_addr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic predict();
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g0 = !reset && r0 && (!r1 || ref_last);
    g1 = !reset && r1 && !g0;
    e_wr0  = reset || (r0 && !g0);
    e_wr1  = reset || (r1 && !g1);
    e_cs   = g0 || g1;
    e_addr = g0 ? m0_address : m1_address;
    e_we   = g0 ? m0_write : m1_write;
    e_rdv0 = !reset && p_valid && !p_id;
    e_rdv1 = !reset && p_valid && p_id;
  endtask

  task automatic advance();
    logic [12:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          we;
    predict();
    p_valid = 0;
    if (reset) begin
      ref_last = 1;
    end else if (g0 || g1) begin
      a  = g0 ? m0_address : m1_address;
      be = g0 ? m0_byteenable : m1_byteenable;
      wd = g0 ? m0_writedata : m1_writedata;
      we = g0 ? m0_write : m1_write;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        p_valid = 1;
        p_id    = g1;
        p_data  = ref_mem[a];
      end
      ref_last = g1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    predict();
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    tick();
    m0_read = 1;
    m1_write = 1;
    sample();
    n_cmp++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      n_err++;
      $display("FAIL rst_wait: got %b%b want 11",
               m0_waitrequest, m1_waitrequest);
    end
    n_cmp++;
    if (mem_chipselect !== 1'b0) begin
      n_err++;
      $display("FAIL rst_cs: got %b want 0", mem_chipselect);
    end
    n_cmp++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rdv: got %b%b want 00",
               m0_readdatavalid, m1_readdatavalid);
    end
    n_cmp++;
    if (mem_reset_req !== 1'b1 || mem_clken !== 1'b1) begin
      n_err++;
      $display("FAIL rst_tie: got rr=%b ck=%b want 1 1",
               mem_reset_req, mem_clken);
    end
    tick();
    reset = 0;
    idle();
    sample();
    n_cmp++;
    if (mem_reset_req !== 1'b0 || m0_waitrequest !== 1'b0) begin
      n_err++;
      $display("FAIL rst_exit: got rr=%b wr0=%b want 0 0",
               mem_reset_req, m0_waitrequest);
    end
    tick();
  endtask

  task automatic test_single_read();
    m0_read = 1;
    m0_address = 13'h0005;
    sample();
    n_cmp++;
    if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 ||
        mem_address !== 13'h0005) begin
      n_err++;
      $display("FAIL single_req: got wr=%b cs=%b a=%h want 0 1 0005",
               m0_waitrequest, mem_chipselect, mem_address);
    end
    tick();
    idle();
    sample();
    n_cmp++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEAD0005) begin
      n_err++;
      $display("FAIL single_rsp: got v=%b d=%h want 1 DEAD0005",
               m0_readdatavalid, m0_readdata);
    end
    n_cmp++;
    if (m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_m1v: got %b want 0", m1_readdatavalid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    m0_read = 1; m0_address = 13'h0010;
    m1_read = 1; m1_address = 13'h1FFF;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) idle();
      sample();
      n_cmp++;
      if (m0_waitrequest !== e_wr0 || m1_waitrequest !== e_wr1) begin
        n_err++;
        $display("FAIL b2b_wait c%0d: got %b%b want %b%b", i,
                 m0_waitrequest, m1_waitrequest, e_wr0, e_wr1);
      end
      n_cmp++;
      if (m0_readdatavalid !== e_rdv0 || m1_readdatavalid !== e_rdv1) begin
        n_err++;
        $display("FAIL b2b_rdv c%0d: got %b%b want %b%b", i,
                 m0_readdatavalid, m1_readdatavalid, e_rdv0, e_rdv1);
      end
      if (p_valid) begin
        n_cmp++;
        if (mem_readdata !== p_data) begin
          n_err++;
          $display("FAIL b2b_data c%0d: got %h want %h", i,
                   mem_readdata, p_data);
        end
      end
      if (i < 8 && !m0_waitrequest) n0++;
      if (i < 8 && !m1_waitrequest) n1++;
      tick();
    end
    n_cmp++;
    if (n0 != 4 || n1 != 4) begin
      n_err++;
      $display("FAIL b2b_share: got %0d/%0d want 4/4", n0, n1);
    end
  endtask

  task automatic test_raw();
    logic [31:0] want [2];
    logic [31:0] wdat [2];
    logic [3:0]  wbe [2];
    want[0] = 32'h12345678; wdat[0] = 32'h12345678; wbe[0] = 4'hF;
    want[1] = 32'h1234CCDD; wdat[1] = 32'hAABBCCDD; wbe[1] = 4'h3;
    for (int k = 0; k < 2; k++) begin
      idle();
      m1_write = 1;
      m1_address = 13'h0100;
      m1_writedata = wdat[k];
      m1_byteenable = wbe[k];
      tick();
      idle();
      m0_read = 1;
      m0_address = 13'h0100;
      sample();
      n_cmp++;
      if (m0_waitrequest !== 1'b0) begin
        n_err++;
        $display("FAIL raw_req%0d: got wr=%b want 0", k, m0_waitrequest);
      end
      tick();
      idle();
      sample();
      n_cmp++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== want[k]) begin
        n_err++;
        $display("FAIL raw_rsp%0d: got v=%b d=%h want 1 %h", k,
                 m0_readdatavalid, m0_readdata, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_lone_fair();
    int acc = 0;
    int waits = 0;
    bit got = 0;
    do_reset();
    m1_read = 1;
    for (int i = 0; i < 10; i++) begin
      m1_address = 13'($urandom_range(0, 8191));
      sample();
      n_cmp++;
      if (m1_waitrequest !== 1'b0 || m1_readdatavalid !== e_rdv1) begin
        n_err++;
        $display("FAIL lone c%0d: got wr=%b v=%b want 0 %b", i,
                 m1_waitrequest, m1_readdatavalid, e_rdv1);
      end
      if (!m1_waitrequest) acc++;
      tick();
    end
    n_cmp++;
    if (acc != 10) begin
      n_err++;
      $display("FAIL lone_cnt: got %0d want 10", acc);
    end
    m0_read = 1;
    m0_address = 13'h0033;
    for (int i = 0; i < 4 && !got; i++) begin
      sample();
      n_cmp++;
      if (m0_waitrequest !== e_wr0) begin
        n_err++;
        $display("FAIL fair_wr c%0d: got %b want %b", i,
                 m0_waitrequest, e_wr0);
      end
      if (!m0_waitrequest) got = 1;
      else waits++;
      tick();
    end
    n_cmp++;
    if (!got || waits > 1) begin
      n_err++;
      $display("FAIL fair_wait: got granted=%0d waits=%0d want 1 <=1",
               got, waits);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_read = 1;
    m0_address = 13'h0007;
    sample();
    n_cmp++;
    if (m0_waitrequest !== 1'b0) begin
      n_err++;
      $display("FAIL mid_acc: got %b want 0", m0_waitrequest);
    end
    tick();
    reset = 1;
    m1_read = 1;
    m1_address = 13'h0009;
    sample();
    n_cmp++;
    if (m0_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rdv: got %b want 0", m0_readdatavalid);
    end
    n_cmp++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
        mem_chipselect !== 1'b0) begin
      n_err++;
      $display("FAIL mid_wait: got %b%b cs=%b want 11 cs=0",
               m0_waitrequest, m1_waitrequest, mem_chipselect);
    end
    tick();
    reset = 0;
    sample();
    n_cmp++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 ||
        m0_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_first: got wr=%b%b v=%b want 01 v=0",
               m0_waitrequest, m1_waitrequest, m0_readdatavalid);
    end
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic test_read_write();
    m0_read = 1;
    m0_write = 1;
    m0_address = 13'h0002;
    m0_writedata = 32'hCAFEF00D;
    sample();
    n_cmp++;
    if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin
      n_err++;
      $display("FAIL rw_req: got cs=%b we=%b want 1 1",
               mem_chipselect, mem_write);
    end
    tick();
    idle();
    sample();
    n_cmp++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL rw_norsp: got %b%b want 00",
               m0_readdatavalid, m1_readdatavalid);
    end
    m0_read = 1;
    m0_address = 13'h0002;
    tick();
    idle();
    sample();
    n_cmp++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hCAFEF00D) begin
      n_err++;
      $display("FAIL rw_data: got v=%b d=%h want 1 CAFEF00D",
               m0_readdatavalid, m0_readdata);
    end
    tick();
  endtask

  task automatic rand_m(input int n);
    int k;
    k = $urandom_range(0, 4);
    if (n == 0) begin
      m0_read = (k == 1 || k == 4);
      m0_write = (k == 2 || k == 4);
      m0_address = 13'($urandom_range(0, 15));
      m0_byteenable = 4'($urandom_range(0, 15));
      m0_writedata = $urandom;
    end else begin
      m1_read = (k == 1 || k == 4);
      m1_write = (k == 2 || k == 4);
      m1_address = 13'($urandom_range(0, 15));
      m1_byteenable = 4'($urandom_range(0, 15));
      m1_writedata = $urandom;
    end
  endtask

  task automatic test_random();
    bit w0, w1;
    rand_m(0);
    rand_m(1);
    for (int i = 0; i < 300; i++) begin
      sample();
      n_cmp++;
      if (m0_waitrequest !== e_wr0 || m1_waitrequest !== e_wr1 ||
          mem_chipselect !== e_cs) begin
        n_err++;
        $display("FAIL rnd_gnt c%0d: got %b%b cs=%b want %b%b cs=%b", i,
                 m0_waitrequest, m1_waitrequest, mem_chipselect,
                 e_wr0, e_wr1, e_cs);
      end
      if (e_cs) begin
        n_cmp++;
        if (mem_address !== e_addr || mem_write !== e_we) begin
          n_err++;
          $display("FAIL rnd_mem c%0d: got a=%h we=%b want a=%h we=%b",
                   i, mem_address, mem_write, e_addr, e_we);
        end
      end
      n_cmp++;
      if (m0_readdatavalid !== e_rdv0 || m1_readdatavalid !== e_rdv1) begin
        n_err++;
        $display("FAIL rnd_rdv c%0d: got %b%b want %b%b", i,
                 m0_readdatavalid, m1_readdatavalid, e_rdv0, e_rdv1);
      end
      if (p_valid) begin
        n_cmp++;
        if (mem_readdata !== p_data) begin
          n_err++;
          $display("FAIL rnd_data c%0d: got %h want %h", i,
                   mem_readdata, p_data);
        end
      end
      w0 = e_wr0;
      w1 = e_wr1;
      tick();
      if (!w0) rand_m(0);
      if (!w1) rand_m(1);
    end
    idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 32'hDEAD0000 | 32'(i);
      ref_mem[i] = 32'hDEAD0000 | 32'(i);
    end
    ram_q = '0;
    ref_last = 1;
    p_valid = 0;
    p_id = 0;
    p_data = '0;
    reset = 1;
    idle();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_raw();
    test_lone_fair();
    test_reset_mid();
    test_read_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
